// File: rtl/pio_input_debounce.sv
// Board switch/key input PIO: 2-FF sync, tick-sampled debounce, sticky rising-edge capture, Avalon-MM slave (read latency 1).
// Optional interrupt mask and registered irq are built only when PIO_INPUT_IRQ_EN is defined.
module pio_input_debounce #(
  parameter int               WIDTH        = 14,
  parameter logic [WIDTH-1:0] RESET_LEVEL  = 14'h3C00,
  parameter int               TICK_CYCLES  = 250000,
  parameter int               STABLE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_raw,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [WIDTH-1:0] sync_s1;
  logic [WIDTH-1:0] sync;
  logic [PW-1:0]    pcnt;
  logic             tick;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] mask_rd;
  logic [31:0]      rd_word;
  logic             unused_wd;

  assign unused_wd = ^writedata[31:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1 <= RESET_LEVEL;
      sync    <= RESET_LEVEL;
    end else begin
      sync_s1 <= in_raw;
      sync    <= sync_s1;
    end
  end

  assign tick = (pcnt == PW'(TICK_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Each bit counts consecutive disagreeing ticks; any agreeing tick restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          stable_b;

    assign cnt_inc   = cnt + CW'(1);
    assign stable[i] = stable_b;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt      <= '0;
        stable_b <= RESET_LEVEL[i];
      end else if (tick) begin
        if (sync[i] != stable_b) begin
          if (cnt_inc == CW'(STABLE_TICKS)) begin
            stable_b <= sync[i];
            cnt      <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

  assign edge_clr = (write && address == 2'd1) ? writedata[WIDTH-1:0] : '0;

  // A rise detected this cycle wins over a simultaneous W1C of the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= RESET_LEVEL;
      edge_r   <= '0;
    end else begin
      stable_d <= stable;
      edge_r   <= (edge_r & ~edge_clr) | (stable & ~stable_d);
    end
  end

`ifdef PIO_INPUT_IRQ_EN
  logic [WIDTH-1:0] mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (write && address == 2'd2) begin
        mask <= writedata[WIDTH-1:0];
      end
      irq <= |(edge_r & mask);
    end
  end

  assign mask_rd = mask;
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    rd_word = '0;
    case (address)
      2'd0:    rd_word[WIDTH-1:0] = stable;
      2'd1:    rd_word[WIDTH-1:0] = edge_r;
      2'd2:    rd_word[WIDTH-1:0] = mask_rd;
      default: rd_word[WIDTH-1:0] = sync;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata <= '0;
    end else if (read) begin
      readdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_pio_input_debounce.sv
// Bench for pio_input_debounce: random and directed stimulus against a tick-history reference model with a read scoreboard.
module tb_pio_input_debounce;

  localparam int          W  = 14;
  localparam logic [13:0] RL = 14'h3C00;
  localparam int          T  = 4;
  localparam int          S  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_raw;
  logic [1:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;

  pio_input_debounce #(
    .WIDTH(W), .RESET_LEVEL(RL), .TICK_CYCLES(T), .STABLE_TICKS(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_raw(in_raw), .address(address),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: debounce decided from the recorded per-tick samples of the synchronized input.
  int           n_cyc;
  logic [W-1:0] raw_q[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_prev, m_edge, m_mask;
  logic         m_irq;
  logic [31:0]  exp_q[$];

  task automatic model_reset();
    n_cyc = 0;
    raw_q.delete();
    raw_q.push_back(RL);
    raw_q.push_back(RL);
    hist.delete();
    m_stable = RL;
    m_prev   = RL;
    m_edge   = '0;
    m_mask   = '0;
    m_irq    = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [W-1:0] sync_v, new_stable, clr, new_edge;
    logic         differ;
    sync_v = raw_q[0];
    if (read) begin
      case (address)
        2'd0: exp_q.push_back(32'(m_stable));
        2'd1: exp_q.push_back(32'(m_edge));
`ifdef PIO_INPUT_IRQ_EN
        2'd2: exp_q.push_back(32'(m_mask));
`else
        2'd2: exp_q.push_back(32'd0);
`endif
        default: exp_q.push_back(32'(sync_v));
      endcase
    end
    new_stable = m_stable;
    if (n_cyc % T == T - 1) begin
      hist.push_back(sync_v);
      if (hist.size() > S) void'(hist.pop_front());
      if (hist.size() == S) begin
        for (int b = 0; b < W; b++) begin
          differ = 1'b1;
          for (int k = 0; k < S; k++)
            if (hist[k][b] == m_stable[b]) differ = 1'b0;
          if (differ) new_stable[b] = sync_v[b];
        end
      end
    end
    clr      = (write && address == 2'd1) ? writedata[W-1:0] : '0;
    new_edge = (m_edge & ~clr) | (m_stable & ~m_prev);
`ifdef PIO_INPUT_IRQ_EN
    m_irq = |(m_edge & m_mask);
    if (write && address == 2'd2) m_mask = writedata[W-1:0];
`endif
    m_prev   = m_stable;
    m_stable = new_stable;
    m_edge   = new_edge;
    n_cyc++;
    raw_q.push_back(in_raw);
    void'(raw_q.pop_front());
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Monitor: pops an expected word whenever a read completes, otherwise readdata must hold.
  logic        rd_s;
  logic [31:0] last_rd;
  logic [31:0] e_rd;

  always @(posedge clk) begin
    if (!rst_n) begin
      last_rd = '0;
    end else begin
      rd_s = read;
      #1;
      if (rst_n) begin
        if (rd_s) begin
          if (exp_q.size() == 0) begin
            check("rd_underflow", 32'd1, 32'd0);
          end else begin
            e_rd = exp_q.pop_front();
            check("readdata", readdata, e_rd);
            last_rd = e_rd;
          end
        end else begin
          check("rd_hold", readdata, last_rd);
        end
        check("irq", 32'(irq), 32'(m_irq));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a);
    read = 1'b1; address = a;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    write = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst_n = 1'b0; in_raw = RL; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    idle(3);
    rst_n = 1'b1;
    #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    do_read(2'd0);
    do_read(2'd3);

    // Debounced step on bit 0, polled every cycle
    in_raw[0] = 1'b1;
    for (int i = 0; i < 14; i++) do_read(2'd0);
    do_read(2'd1);

    // Glitch shorter than a tick period on bit 1
    in_raw[1] = 1'b1;
    idle(3);
    in_raw[1] = 1'b0;
    for (int i = 0; i < 12; i++) do_read(i[0] ? 2'd1 : 2'd0);

    // W1C, then clear coinciding with a new rise
    in_raw[1] = 1'b1;
    idle(14);
    do_read(2'd1);
    do_write(2'd1, 32'h1);
    do_read(2'd1);
    in_raw[0] = 1'b0;
    idle(14);
    in_raw[0] = 1'b1;
    guard = 0;
    while (!(m_stable[0] && !m_prev[0]) && guard < 30) begin idle(1); guard++; end
    if (guard >= 30) check("rise_wait_timeout", 32'd1, 32'd0);
    read = 1'b1;
    do_write(2'd1, 32'h1);
    read = 1'b0;
    do_read(2'd1);

    // Interrupt path on KEY0
    do_write(2'd2, 32'h0400);
    do_read(2'd2);
    in_raw[10] = 1'b0;
    idle(14);
    in_raw[10] = 1'b1;
    idle(14);
    do_read(2'd1);
    do_write(2'd1, 32'h0400);
    idle(3);
    do_read(2'd2);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        int b;
        b = $urandom_range(0, W - 1);
        in_raw[b] = ~in_raw[b];
      end
      read      = ($urandom_range(0, 1) == 1);
      write     = ($urandom_range(0, 5) == 0);
      address   = 2'($urandom_range(0, 3));
      writedata = $urandom;
      @(negedge clk);
    end
    read = 1'b0; write = 1'b0;

    // Reset with one disagreeing tick counted on bit 0 and its edge captured
    do_write(2'd1, 32'hFFFF_FFFF);
    in_raw = RL;
    idle(14);
    in_raw[0] = 1'b1;
    guard = 0;
    while (!m_edge[0] && guard < 30) begin idle(1); guard++; end
    if (guard >= 30) check("edge_wait_timeout", 32'd1, 32'd0);
    in_raw[0] = 1'b0;
    guard = 0;
    while (!(hist.size() > 0 && hist[hist.size()-1][0] == 1'b0) && guard < 30) begin idle(1); guard++; end
    if (guard >= 30) check("tick_wait_timeout", 32'd1, 32'd0);
    #2 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    #1;
    check("rst2_readdata", readdata, 32'd0);
    check("rst2_irq", 32'(irq), 32'd0);
    do_read(2'd0);
    do_read(2'd1);
    idle(12);
    do_read(2'd0);
    do_read(2'd1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
